// File: rtl/freq_div_pkg.sv
// Shared definitions for the programmable frequency divider: default width and
// the direction-dependent terminal count.
package freq_div_pkg;

   localparam int DIV_WIDTH = 8;

   // Signed so a width cast sign-extends all-ones for counters wider than DIV_WIDTH.
   function automatic logic signed [DIV_WIDTH-1:0] terminal_value(input logic dn);
      return dn ? '0 : '1;
   endfunction

endpackage

// File: rtl/programmable_freq_divider_if.sv
// Control/status bundle of the divider: divisor, direction and preset in,
// counter value and divided outputs back.
import freq_div_pkg::*;

interface programmable_freq_divider_if #(
   parameter int WIDTH = DIV_WIDTH
);
   logic             preset_n;
   logic             dn;
   logic [WIDTH-1:0] div_in;
   logic [WIDTH-1:0] q;
   logic             div_out;
   logic             tc_n;
   logic             half_out;

   modport master (
      output preset_n, dn, div_in,
      input  q, div_out, tc_n, half_out
   );

   modport slave (
      input  preset_n, dn, div_in,
      output q, div_out, tc_n, half_out
   );
endinterface

// File: rtl/updown_load_counter.sv
// Loadable up/down counter with synchronous active-low clear and a flag that is
// high while the count sits at the terminal value for the current direction.
import freq_div_pkg::*;

module updown_load_counter #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_clear_n,
   input  logic             i_load,
   input  logic             i_dn,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_q,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_term;

   assign w_term = WIDTH'(terminal_value(i_dn));

   always_ff @(posedge i_clk) begin
      if (!i_clear_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_val;
      end else if (i_dn) begin
         r_q <= r_q - WIDTH'(1);
      end else begin
         r_q <= r_q + WIDTH'(1);
      end
   end

   assign o_q  = r_q;
   assign o_tc = (r_q == w_term);

endmodule

// File: rtl/programmable_freq_divider.sv
// Programmable divider: counter reloads div_in at terminal count, giving a
// one-cycle pulse every N clocks. Half-duty toggle output exists only when
// FREQ_DIV_HALF_DUTY_EN is defined; otherwise half_out is tied low.
import freq_div_pkg::*;

module programmable_freq_divider #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                           clk,
   input  logic                           clear,
   programmable_freq_divider_if.slave     bus
);

   logic             w_load;
   logic             w_tc;
   logic [WIDTH-1:0] w_q;

   // Preset and terminal-count reload share the same load path; clear wins inside the counter.
   assign w_load = ~bus.preset_n | w_tc;

   updown_load_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .i_clk      (clk),
      .i_clear_n  (clear),
      .i_load     (w_load),
      .i_dn       (bus.dn),
      .i_load_val (bus.div_in),
      .o_q        (w_q),
      .o_tc       (w_tc)
   );

   assign bus.q       = w_q;
   assign bus.div_out = w_tc;
   assign bus.tc_n    = ~w_tc;

`ifdef FREQ_DIV_HALF_DUTY_EN
   logic r_half;

   // A preset takes priority over the reload, so the toggle holds on preset edges.
   always_ff @(posedge clk) begin
      if (!clear) begin
         r_half <= 1'b0;
      end else if (bus.preset_n && w_tc) begin
         r_half <= ~r_half;
      end
   end

   assign bus.half_out = r_half;
`else
   assign bus.half_out = 1'b0;
`endif

endmodule

// File: tb/tb_programmable_freq_divider.sv
// Scoreboard bench for programmable_freq_divider: stimulus pushes expected
// outputs per edge, a monitor pops and compares, plus pulse-period checks.
module tb_programmable_freq_divider;

`ifdef FREQ_DIV_HALF_DUTY_EN
   localparam bit HALF_EN = 1'b1;
`else
   localparam bit HALF_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] q;
      logic       div_out;
      logic       tc_n;
      logic       half;
   } exp_t;

   logic clk;
   logic clear;
   exp_t sb_q[$];

   int checks = 0;
   int errors = 0;

   logic [7:0] m_q    = 8'h00;
   logic       m_half = 1'b0;

   int p_rearm    = 0;
   int exp_period = 0;
   int p_cnt      = 0;
   int h_cnt      = 0;
   bit p_armed    = 0;
   bit h_armed    = 0;
   logic h_last   = 1'b0;

   programmable_freq_divider_if #(.WIDTH(8)) dif ();

   programmable_freq_divider #(.WIDTH(8)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one edge worth of inputs and push what the outputs must be after it.
   task automatic step(input logic c, input logic p, input logic d, input logic [7:0] v);
      logic [7:0] term;
      exp_t e;
      @(negedge clk);
      clear        = c;
      dif.preset_n = p;
      dif.dn       = d;
      dif.div_in   = v;
      term = d ? 8'h00 : 8'hFF;
      if (!c) begin
         m_q    = 8'h00;
         m_half = 1'b0;
      end else if (!p) begin
         m_q = v;
      end else if (m_q == term) begin
         m_q    = v;
         m_half = ~m_half;
      end else begin
         m_q = d ? m_q - 8'h01 : m_q + 8'h01;
      end
      e.q       = m_q;
      e.div_out = (m_q == term);
      e.tc_n    = ~e.div_out;
      e.half    = HALF_EN ? m_half : 1'b0;
      sb_q.push_back(e);
   endtask

   task automatic run_to(input logic d, input logic [7:0] v, input logic [7:0] target);
      int n;
      n = 0;
      while (m_q != target && n < 300) begin
         step(1'b1, 1'b1, d, v);
         n++;
      end
      if (m_q != target) begin
         errors++;
         $display("FAIL run_to: timed out, got %0h expected %0h", m_q, target);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("q",        dif.q,        e.q);
         chk("div_out",  dif.div_out,  e.div_out);
         chk("tc_n",     dif.tc_n,     e.tc_n);
         chk("half_out", dif.half_out, e.half);
         if (p_rearm != 0) begin
            p_armed = (p_rearm == 2);
            p_cnt   = 0;
            h_armed = 0;
            h_cnt   = 0;
            h_last  = dif.half_out;
            p_rearm = 0;
         end else begin
            p_cnt++;
            h_cnt++;
            if (dif.div_out === 1'b1) begin
               if (p_armed && exp_period != 0) chk("div_period", p_cnt, exp_period);
               p_armed = 1;
               p_cnt   = 0;
            end
            if (dif.half_out !== h_last) begin
               if (h_armed && exp_period != 0) chk("half_run", h_cnt, exp_period);
               h_armed = 1;
               h_cnt   = 0;
               h_last  = dif.half_out;
            end
         end
      end
   end

   initial begin
      clear        = 1'b0;
      dif.preset_n = 1'b1;
      dif.dn       = 1'b1;
      dif.div_in   = 8'h99;

      // Reset, then divide-down by 154.
      step(1'b0, 1'b1, 1'b1, 8'h99);
      p_rearm = 1; exp_period = 0;
      step(1'b1, 1'b1, 1'b1, 8'h99);
      exp_period = 154;
      repeat (3 * 154 + 5) step(1'b1, 1'b1, 1'b1, 8'h99);

      // Divide-up by 103.
      step(1'b1, 1'b0, 1'b0, 8'h99);
      p_rearm = 1; exp_period = 0;
      step(1'b1, 1'b1, 1'b0, 8'h99);
      exp_period = 103;
      repeat (3 * 103 + 10) step(1'b1, 1'b1, 1'b0, 8'h99);

      // Preset mid-count at q=0x40 with div_in=0x10.
      step(1'b1, 1'b0, 1'b1, 8'h99);
      p_rearm = 1; exp_period = 0;
      run_to(1'b1, 8'h99, 8'h40);
      step(1'b1, 1'b0, 1'b1, 8'h10);
      p_rearm = 2; exp_period = 16;
      repeat (17) step(1'b1, 1'b1, 1'b1, 8'h10);
      exp_period = 17;
      repeat (40) step(1'b1, 1'b1, 1'b1, 8'h10);

      // Degenerate N=1.
      step(1'b1, 1'b0, 1'b1, 8'h00);
      p_rearm = 1; exp_period = 1;
      repeat (10) step(1'b1, 1'b1, 1'b1, 8'h00);

      // div_in change mid-period only affects the next reload.
      step(1'b1, 1'b0, 1'b1, 8'h20);
      p_rearm = 2; exp_period = 32;
      repeat (10) step(1'b1, 1'b1, 1'b1, 8'h20);
      repeat (23) step(1'b1, 1'b1, 1'b1, 8'h05);
      exp_period = 6;
      repeat (20) step(1'b1, 1'b1, 1'b1, 8'h05);

      // Mid-operation clear at q=0x55.
      step(1'b1, 1'b0, 1'b1, 8'h99);
      p_rearm = 1; exp_period = 0;
      run_to(1'b1, 8'h99, 8'h55);
      step(1'b0, 1'b1, 1'b1, 8'h99);
      repeat (3) step(1'b1, 1'b1, 1'b1, 8'h99);

      // Direction flip at q=0x80.
      step(1'b1, 1'b0, 1'b1, 8'h99);
      p_rearm = 1; exp_period = 0;
      run_to(1'b1, 8'h99, 8'h80);
      step(1'b1, 1'b1, 1'b0, 8'h99);
      p_rearm = 2; exp_period = 126;
      repeat (126) step(1'b1, 1'b1, 1'b0, 8'h99);
      step(1'b1, 1'b1, 1'b0, 8'h99);
      exp_period = 103;
      repeat (110) step(1'b1, 1'b1, 1'b0, 8'h99);

      repeat (2) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
